// File: rtl/shift_pkg.sv
// Shared definitions for the sequential shifter: op codes and FSM states.
// Used by shift_step and shift_unit_seq.
package shift_pkg;

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shift of i_data by i_k positions; returns {carry, data}.
// SHIFT_UNIT_ROR_EN: when defined op 11 rotates right, otherwise op 11 passes data through.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int KW    = 5
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic [1:0]       i_op,
    input  logic [KW-1:0]    i_k,
    output logic [WIDTH:0]   o_res
);

    logic [WIDTH:0]        w_lsl;
    logic [WIDTH:0]        w_lsr;
    logic signed [WIDTH:0] w_asr;

    // Extra bit on the outgoing side captures the last bit shifted out
    assign w_lsl = {1'b0, i_data} << i_k;
    assign w_lsr = {i_data, 1'b0} >> i_k;
    assign w_asr = $signed({i_data, 1'b0}) >>> i_k;

`ifdef SHIFT_UNIT_ROR_EN
    logic [2*WIDTH-1:0] w_cat;
    logic [WIDTH-1:0]   w_ror;

    assign w_cat = {i_data, i_data};
    assign w_ror = WIDTH'(w_cat >> i_k);
`endif

    // Select the shifted word and its carry for the requested op
    always_comb begin
        o_res = {1'b0, i_data};
        case (i_op)
            OP_LSL:  o_res = w_lsl;
            OP_LSR:  o_res = {w_lsr[0], w_lsr[WIDTH:1]};
            OP_ASR:  o_res = {w_asr[0], w_asr[WIDTH:1]};
`ifdef SHIFT_UNIT_ROR_EN
            OP_ROR:  o_res = {w_ror[WIDTH-1], w_ror};
`else
            OP_ROR:  o_res = {1'b0, i_data};
`endif
            default: o_res = {1'b0, i_data};
        endcase
    end

endmodule

// File: rtl/shift_unit_seq.sv
// Multi-cycle shifter: shifts by 0..WIDTH, up to STEP positions per clock, valid/ready on both sides.
// SHIFT_UNIT_ROR_EN: enables rotate-right on op 11 (otherwise op 11 is a pass-through).
module shift_unit_seq
    import shift_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int STEP  = 1,
    localparam int AW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AW-1:0]    in_amt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             busy
);

    localparam logic [AW-1:0] W_A = AW'(WIDTH);
    localparam logic [AW-1:0] S_A = AW'(STEP);

    state_t           r_state;
    state_t           w_next;
    logic [AW-1:0]    r_rem;
    logic [WIDTH-1:0] r_data;
    logic             r_carry;
    logic [1:0]       r_op;
    logic [AW-1:0]    w_eff;
    logic [AW-1:0]    w_k;
    logic             w_acc;
    logic [WIDTH:0]   w_step;

    assign w_acc = in_valid && (r_state == S_IDLE);
    assign w_k   = (r_rem > S_A) ? S_A : r_rem;

    // Effective amount: clamp for shifts, modulo for rotate, zero for pass-through
    always_comb begin
        w_eff = (in_amt > W_A) ? W_A : in_amt;
        if (in_op == OP_ROR) begin
`ifdef SHIFT_UNIT_ROR_EN
            w_eff = in_amt % W_A;
`else
            w_eff = '0;
`endif
        end
    end

    shift_step #(
        .WIDTH (WIDTH),
        .KW    (AW)
    ) u_step (
        .i_data (r_data),
        .i_op   (r_op),
        .i_k    (w_k),
        .o_res  (w_step)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_acc) w_next = (w_eff == '0) ? S_DONE : S_SHIFT;
            S_SHIFT: if (r_rem <= S_A) w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operand capture on accept, then one step per cycle while shifting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data  <= '0;
            r_carry <= 1'b0;
            r_op    <= OP_LSL;
            r_rem   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        r_data  <= in_data;
                        r_op    <= in_op;
                        r_rem   <= w_eff;
                        r_carry <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    {r_carry, r_data} <= w_step;
                    r_rem             <= r_rem - w_k;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign out_data  = r_data;
    assign out_carry = r_carry;

endmodule
